regfile_access_arbiter: RTL
===========================

REGFILE_ACCESS_ARBITER -- requirements
Module: regfile_access_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have ports req0_valid / req1_valid, input, 1 each, request pending from requester 0 (control unit) / 1 (I/O port).
REQ-004 SHALL have ports req0_we / req1_we, input, 1 each, 1 = write, 0 = read.
REQ-005 SHALL have ports req0_sel / req1_sel, input, 2 each, target register: 00 = X, 01 = Y, 10 = accumulator, 11 = reserved.
REQ-006 SHALL have ports req0_wdata / req1_wdata, input, 16 each, write data.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1 each, request accepted this cycle.
REQ-008 SHALL have ports req0_rvalid / req1_rvalid, output, 1 each, one-cycle completion pulse.
REQ-009 SHALL have ports req0_rdata / req1_rdata, output, 16 each, read result, valid with rvalid.
REQ-010 SHALL have port err, output, 1, pulses with rvalid when the completed request used sel = 11.
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-012 SHALL have port gpr_data_in, output, 16, write data to the register bank.
REQ-013 SHALL have ports gpr_write_x, gpr_write_y, gpr_write_acc, output, 1 each, register bank write strobes.
REQ-014 SHALL have ports gpr_read_x, gpr_read_y, gpr_read_acc, output, 1 each, register bank read enables.
REQ-015 SHALL have ports gpr_data_out, gpr_data_out_acc, input, 16 each, combinational read data from the bank (X/Y port, accumulator port).

Function
REQ-016 SHALL implement the FSM IDLE -> EXEC -> RESP -> IDLE, one cycle in each of EXEC and RESP.
REQ-017 IDLE: if either valid is high, SHALL grant exactly one requester, assert that requester's ready combinationally for that cycle, and latch we/sel/wdata/grant id; then go to EXEC.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of pointer.
REQ-019 The pointer SHALL update on RESP exit to the id just served.
REQ-020 ready SHALL be low in EXEC and RESP; valid is sampled only in IDLE. Requesters hold valid and operands until ready.
REQ-021 EXEC, write: SHALL assert exactly one gpr_write_* per sel, with gpr_data_in = latched wdata.
REQ-022 EXEC, read: SHALL assert exactly one gpr_read_* per sel, and register gpr_data_out (X/Y) or gpr_data_out_acc (accumulator) at the end of EXEC.
REQ-023 sel = 11: SHALL assert no gpr strobe; rdata SHALL be 0 and err SHALL pulse in RESP.
REQ-024 RESP: SHALL pulse rvalid of the granted requester only, with rdata = captured data (reads) or 0 (writes); the other requester's rvalid and rdata stay 0.
REQ-025 Latency: ready at cycle T, gpr strobe at T+1, rvalid at T+2; next ready no earlier than T+3.
REQ-026 All gpr strobes SHALL be low outside EXEC; at most one strobe is high in any cycle; gpr_data_in SHALL be 0 outside write EXEC.
REQ-027 A read accepted after a write to the same register SHALL return the written value, because the write commits at the end of its EXEC.
REQ-028 A valid deasserted before ready SHALL be ignored; no transaction is recorded.

Reset
REQ-029 With rst high at a clock edge: state = IDLE, pointer favours requester 0, latched request cleared, and all outputs (ready, rvalid, rdata, err, busy, gpr_*) = 0 from the next cycle.
REQ-030 Reset in EXEC or RESP SHALL abort the transaction; no rvalid follows. A write whose EXEC edge coincides with rst SHALL NOT strobe after reset.

Verification
REQ-031 Reset, then req0 writes X = 16'hA5A5 -> req0_ready at T, gpr_write_x with gpr_data_in = A5A5 at T+1, req0_rvalid with rdata = 0 at T+2.
REQ-032 req1 reads X after REQ-031, bank returns A5A5 -> gpr_read_x at T+1, req1_rvalid with req1_rdata = A5A5 at T+2, req0_rvalid = 0.
REQ-033 Both valid continuously (req0 writes ACC = 16'h1234, req1 reads ACC) -> grants alternate 0,1,0,1 after reset; req1 read returns 1234.
REQ-034 req0 with sel = 11 -> no gpr strobe, rvalid with rdata = 0 and err = 1 at T+2.
REQ-035 rst asserted during EXEC of a req1 write Y = 16'hFACE -> no rvalid, all outputs 0; the next request with both valid grants req0.
REQ-036 Exhaustive check: a single gpr strobe per transaction and none in IDLE or RESP over 1000 random requests.

Source files
------------

// File: rtl/regfile_access_arbiter_if.sv
// Requester-side bus of the register-file access arbiter: two request/response
// channels (control unit, I/O port) plus the shared error and busy indications.
interface regfile_access_arbiter_if;
  logic        req0_valid;
  logic        req0_we;
  logic [1:0]  req0_sel;
  logic [15:0] req0_wdata;
  logic        req0_ready;
  logic        req0_rvalid;
  logic [15:0] req0_rdata;

  logic        req1_valid;
  logic        req1_we;
  logic [1:0]  req1_sel;
  logic [15:0] req1_wdata;
  logic        req1_ready;
  logic        req1_rvalid;
  logic [15:0] req1_rdata;

  logic        err;
  logic        busy;

  modport master (
    output req0_valid, req0_we, req0_sel, req0_wdata,
    output req1_valid, req1_we, req1_sel, req1_wdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  err, busy
  );

  modport slave (
    input  req0_valid, req0_we, req0_sel, req0_wdata,
    input  req1_valid, req1_we, req1_sel, req1_wdata,
    output req0_ready, req0_rvalid, req0_rdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output err, busy
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter giving two requesters single-access turns at the X/Y/ACC
// register bank through an IDLE -> EXEC -> RESP sequence.
module regfile_access_arbiter (
  input  logic                    clk,
  input  logic                    rst,
  regfile_access_arbiter_if.slave bus,
  output logic [15:0]             gpr_data_in,
  output logic                    gpr_write_x,
  output logic                    gpr_write_y,
  output logic                    gpr_write_acc,
  output logic                    gpr_read_x,
  output logic                    gpr_read_y,
  output logic                    gpr_read_acc,
  input  logic [15:0]             gpr_data_out,
  input  logic [15:0]             gpr_data_out_acc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SEL_X   = 2'b00;
  localparam logic [1:0] SEL_Y   = 2'b01;
  localparam logic [1:0] SEL_ACC = 2'b10;
  localparam logic [1:0] SEL_RSV = 2'b11;

  state_t      state_r;
  logic        last_r;
  logic        gid_r;
  logic        we_r;
  logic [1:0]  sel_r;

  logic        rvalid0_r;
  logic        rvalid1_r;
  logic [15:0] rdata0_r;
  logic [15:0] rdata1_r;
  logic        err_r;
  logic        busy_r;
  logic [15:0] data_in_r;
  logic [5:0]  strobe_r;

  logic        grant_s;
  logic        grant_id_s;
  logic        g_we_s;
  logic [1:0]  g_sel_s;
  logic [15:0] g_wdata_s;
  logic [5:0]  strobe_s;
  logic [15:0] capture_s;

  // Strobe vector layout: {write_x, write_y, write_acc, read_x, read_y, read_acc}
  function automatic logic [5:0] strobe_decode(input logic we, input logic [1:0] sel);
    logic [2:0] onehot;
    case (sel)
      SEL_X:   onehot = 3'b100;
      SEL_Y:   onehot = 3'b010;
      SEL_ACC: onehot = 3'b001;
      default: onehot = 3'b000;
    endcase
    if (we) begin
      strobe_decode = {onehot, 3'b000};
    end else begin
      strobe_decode = {3'b000, onehot};
    end
  endfunction

  // Round-robin grant, only while idle; last_r holds the id served most recently
  always_comb begin
    grant_s    = 1'b0;
    grant_id_s = 1'b0;
    if ((state_r == ST_IDLE) && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_s    = 1'b1;
        grant_id_s = ~last_r;
      end else if (bus.req0_valid) begin
        grant_s    = 1'b1;
        grant_id_s = 1'b0;
      end else if (bus.req1_valid) begin
        grant_s    = 1'b1;
        grant_id_s = 1'b1;
      end else begin
        grant_s    = 1'b0;
        grant_id_s = 1'b0;
      end
    end else begin
      grant_s    = 1'b0;
      grant_id_s = 1'b0;
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    g_we_s    = 1'b0;
    g_sel_s   = 2'b00;
    g_wdata_s = 16'h0000;
    if (grant_id_s) begin
      g_we_s    = bus.req1_we;
      g_sel_s   = bus.req1_sel;
      g_wdata_s = bus.req1_wdata;
    end else begin
      g_we_s    = bus.req0_we;
      g_sel_s   = bus.req0_sel;
      g_wdata_s = bus.req0_wdata;
    end
  end

  assign strobe_s = grant_s ? strobe_decode(g_we_s, g_sel_s) : 6'b000000;

  // Read data selected from the bank port matching the latched target
  always_comb begin
    capture_s = 16'h0000;
    if (we_r) begin
      capture_s = 16'h0000;
    end else begin
      case (sel_r)
        SEL_X:   capture_s = gpr_data_out;
        SEL_Y:   capture_s = gpr_data_out;
        SEL_ACC: capture_s = gpr_data_out_acc;
        default: capture_s = 16'h0000;
      endcase
    end
  end

  // Transaction FSM; strobes, response and status are all registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      last_r    <= 1'b1;
      gid_r     <= 1'b0;
      we_r      <= 1'b0;
      sel_r     <= 2'b00;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= 16'h0000;
      rdata1_r  <= 16'h0000;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      data_in_r <= 16'h0000;
      strobe_r  <= 6'b000000;
    end else begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= 16'h0000;
      rdata1_r  <= 16'h0000;
      err_r     <= 1'b0;
      data_in_r <= 16'h0000;
      strobe_r  <= 6'b000000;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            state_r  <= ST_EXEC;
            busy_r   <= 1'b1;
            gid_r    <= grant_id_s;
            we_r     <= g_we_s;
            sel_r    <= g_sel_s;
            strobe_r <= strobe_s;
            // The reserved target gets no strobe, so it gets no write data either
            if (g_we_s && (g_sel_s != SEL_RSV)) begin
              data_in_r <= g_wdata_s;
            end else begin
              data_in_r <= 16'h0000;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_EXEC: begin
          state_r <= ST_RESP;
          busy_r  <= 1'b1;
          err_r   <= (sel_r == SEL_RSV);
          if (gid_r) begin
            rvalid1_r <= 1'b1;
            rdata1_r  <= capture_s;
          end else begin
            rvalid0_r <= 1'b1;
            rdata0_r  <= capture_s;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          last_r  <= gid_r;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready  = grant_s & ~grant_id_s;
  assign bus.req1_ready  = grant_s & grant_id_s;
  assign bus.req0_rvalid = rvalid0_r;
  assign bus.req1_rvalid = rvalid1_r;
  assign bus.req0_rdata  = rdata0_r;
  assign bus.req1_rdata  = rdata1_r;
  assign bus.err         = err_r;
  assign bus.busy        = busy_r;

  assign gpr_data_in = data_in_r;
  assign {gpr_write_x, gpr_write_y, gpr_write_acc,
          gpr_read_x, gpr_read_y, gpr_read_acc} = strobe_r;

endmodule
